// File: rtl/expr_pkg.sv
// Shared constants, state encoding and helper functions for the expression
// character generator.
package expr_pkg;

    localparam logic [7:0] CH_ZERO    = 8'h30;
    localparam logic [7:0] CH_PLUS    = 8'h2B;
    localparam logic [7:0] CH_STAR    = 8'h2A;
    localparam logic [7:0] CH_NONE    = 8'h00;

    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam logic [7:0] LFSR_RESET = 8'h01;

    // 3-bit encoding keeps the width aligned with the recognizer's state field.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_OP    = 3'd2
    } expr_state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    // Nibbles 10..15 fold back onto 0..5 so every LFSR value yields a digit.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        logic [3:0] folded;
        folded = (d >= 4'd10) ? d - 4'd10 : d;
        return CH_ZERO + {4'b0000, folded};
    endfunction

    function automatic logic [7:0] char_of(input expr_state_t st, input logic [7:0] v);
        logic [7:0] c;
        case (st)
            ST_DIGIT: c = digit_char(v[3:0]);
            ST_OP:    c = v[4] ? CH_STAR : CH_PLUS;
            default:  c = CH_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/expr_gen_if.sv
// Character handshake between the expression generator and its consumer.
interface expr_gen_if;

    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_char,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_char,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/expr_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and per-transfer advance.
module expr_lfsr8
    import expr_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       advance,
    output logic [7:0] value
);

    // An all-zero seed would lock the register, so it is replaced by 8'h01.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            value <= LFSR_RESET;
        end else if (load) begin
            value <= (load_value == 8'h00) ? LFSR_RESET : load_value;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/expr_gen.sv
// Emits a random expression digit (op digit)* one ASCII character per
// accepted transfer, driven by a seeded LFSR.
module expr_gen
    import expr_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [3:0]        num_terms,
    input  logic [7:0]        seed,
    expr_gen_if.master        chr,
    output logic              busy,
    output logic              done
);

    expr_state_t state;
    logic [3:0]  remaining;
    logic [7:0]  lfsr_value;
    logic        load;
    logic        xfer;

    assign load = (state == ST_IDLE) && start;
    assign xfer = chr.out_valid && chr.out_ready;

    expr_lfsr8 u_lfsr (
        .clk        (clk),
        .clr_n      (clr_n),
        .load       (load),
        .load_value (seed),
        .advance    (xfer),
        .value      (lfsr_value)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            remaining <= 4'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= (num_terms == 4'd0) ? 4'd1 : num_terms;
                        state     <= ST_DIGIT;
                    end
                end
                ST_DIGIT: begin
                    if (xfer) begin
                        if (remaining == 4'd1) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= remaining - 4'd1;
                            state     <= ST_OP;
                        end
                    end
                end
                ST_OP: begin
                    if (xfer) begin
                        state <= ST_DIGIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Character and valid decode straight from registered state and LFSR.
    assign chr.out_valid = (state != ST_IDLE);
    assign chr.out_char  = char_of(state, lfsr_value);
    assign busy          = chr.out_valid;

endmodule

// File: tb/tb_expr_gen.sv
// Randomized self-checking bench for expr_gen against a behavioural stream model.
module tb_expr_gen;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] num_terms = 4'd0;
    logic [7:0] seed = 8'h00;
    logic       busy;
    logic       done;

    expr_gen_if chr();

    expr_gen dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .num_terms (num_terms),
        .seed      (seed),
        .chr       (chr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         ready_pat[$];
    int         hold_err;
    int         cycles;
    bit         done_seen;
    logic       busy_at_done;

    // Expected stream from seed and term count, using plain integer arithmetic.
    task automatic build_model(input int s, input int n);
        int l;
        int terms;
        int fb;
        exp_q.delete();
        l = (s == 0) ? 1 : s;
        terms = (n == 0) ? 1 : n;
        for (int i = 0; i < 2 * terms - 1; i++) begin
            if (i % 2 == 0) exp_q.push_back(8'(48 + (l % 16) % 10));
            else            exp_q.push_back(((l / 16) % 2 == 1) ? 8'h2A : 8'h2B);
            fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
            l  = ((l * 2) + fb) % 256;
        end
    endtask

    task automatic do_start(input logic [7:0] s, input logic [3:0] n);
        seed = s;
        num_terms = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Collects accepted characters until done; rand_ready picks random out_ready.
    task automatic capture(input bit rand_ready, input int max_cycles);
        int         pi;
        bit         r;
        bit         prev_stall;
        logic [7:0] prev_char;
        got.delete();
        hold_err = 0;
        done_seen = 1'b0;
        busy_at_done = 1'bx;
        cycles = 0;
        pi = 0;
        prev_stall = 1'b0;
        prev_char = 8'h00;
        for (int c = 0; c < max_cycles; c++) begin
            if (done) begin
                done_seen = 1'b1;
                busy_at_done = busy;
                break;
            end
            if (prev_stall && (!chr.out_valid || chr.out_char !== prev_char)) hold_err++;
            if (rand_ready) r = 1'($urandom_range(0, 1));
            else if (pi < ready_pat.size()) begin r = (ready_pat[pi] != 0); pi++; end
            else r = 1'b1;
            chr.out_ready = r;
            prev_stall = chr.out_valid && !r;
            prev_char = chr.out_char;
            if (chr.out_valid && r) got.push_back(chr.out_char);
            cycles++;
            @(posedge clk); #1;
        end
        chr.out_ready = 1'b0;
        ready_pat.delete();
    endtask

    task automatic test_reset;
        chr.out_ready = 1'b0;
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (chr.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", chr.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (chr.out_char !== 8'h00) begin bad++; $display("FAIL reset_char got=%h exp=00", chr.out_char); end
        total++; if (dut.u_lfsr.value !== 8'h01) begin bad++; $display("FAIL reset_lfsr got=%h exp=01", dut.u_lfsr.value); end
        clr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        do_start(8'h01, 4'd2);
        total++; if (chr.out_valid !== 1'b1 || chr.out_char !== 8'h31) begin bad++; $display("FAIL first_latency got=%b/%h exp=1/31", chr.out_valid, chr.out_char); end
        capture(1'b0, 50);
        build_model(1, 2);
        total++; if (got.size() !== 3) begin bad++; $display("FAIL basic_len got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL basic_char%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]); end
        end
        total++; if (cycles !== 3) begin bad++; $display("FAIL basic_throughput got=%0d exp=3", cycles); end
        total++; if (!done_seen || busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_done got=%b busy=%b exp=1 busy=0", done_seen, busy_at_done); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    endtask

    task automatic test_single;
        do_start(8'h01, 4'd1);
        capture(1'b0, 50);
        total++; if (got.size() !== 1 || got[0] !== 8'h31 || !done_seen) begin bad++; $display("FAIL single_n1 got=%0d chars first=%h done=%b exp=1 31 1", got.size(), (got.size() > 0) ? got[0] : 8'hxx, done_seen); end
        do_start(8'h00, 4'd0);
        capture(1'b0, 50);
        total++; if (got.size() !== 1 || got[0] !== 8'h31 || !done_seen) begin bad++; $display("FAIL single_zero got=%0d chars first=%h done=%b exp=1 31 1", got.size(), (got.size() > 0) ? got[0] : 8'hxx, done_seen); end
    endtask

    task automatic test_fold;
        do_start(8'h0C, 4'd1);
        capture(1'b0, 50);
        total++; if (got.size() !== 1 || got[0] !== 8'h32) begin bad++; $display("FAIL digit_fold got=%h exp=32", (got.size() > 0) ? got[0] : 8'hxx); end
    endtask

    task automatic test_backpressure;
        do_start(8'h01, 4'd2);
        ready_pat = '{0, 0, 1, 0, 1, 1};
        capture(1'b0, 50);
        total++; if (got.size() !== 3 || got[0] !== 8'h31 || got[1] !== 8'h2B || got[2] !== 8'h34) begin bad++; $display("FAIL bp_stream got=%0d chars exp=31 2b 34", got.size()); end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
        total++; if (!done_seen || cycles !== 6) begin bad++; $display("FAIL bp_done got=%b after %0d exp=1 after 6", done_seen, cycles); end
    endtask

    task automatic test_busy_start_and_reset;
        logic [7:0] c0;
        logic [7:0] c1;
        int         done_hits;
        build_model(1, 5);
        do_start(8'h01, 4'd5);
        chr.out_ready = 1'b1;
        c0 = chr.out_char;
        @(posedge clk); #1;
        seed = 8'hAA; num_terms = 4'd3; start = 1'b1;
        c1 = chr.out_char;
        @(posedge clk); #1;
        start = 1'b0;
        chr.out_ready = 1'b0;
        total++; if (c0 !== 8'h31 || c1 !== 8'h2B) begin bad++; $display("FAIL busy_first_two got=%h %h exp=31 2b", c0, c1); end
        total++; if (chr.out_valid !== 1'b1 || chr.out_char !== exp_q[2]) begin bad++; $display("FAIL busy_start_ignored got=%b/%h exp=1/%h", chr.out_valid, chr.out_char, exp_q[2]); end
        #2 clr_n = 1'b0;
        #1;
        total++; if (chr.out_valid !== 1'b0 || busy !== 1'b0 || dut.u_lfsr.value !== 8'h01) begin bad++; $display("FAIL midreset got valid=%b busy=%b lfsr=%h exp=0 0 01", chr.out_valid, busy, dut.u_lfsr.value); end
        done_hits = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) done_hits++;
            @(posedge clk); #1;
            if (i == 1) clr_n = 1'b1;
        end
        total++; if (done_hits !== 0) begin bad++; $display("FAIL midreset_done got=%0d exp=0", done_hits); end
        do_start(8'h01, 4'd2);
        capture(1'b0, 50);
        total++; if (got.size() !== 3 || got[0] !== 8'h31 || got[1] !== 8'h2B || got[2] !== 8'h34) begin bad++; $display("FAIL after_reset_stream got=%0d chars exp=31 2b 34", got.size()); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s;
        logic [3:0] n;
        int         errs;
        do_start(8'h01, 4'd2);
        capture(1'b0, 50);
        s = 8'($urandom_range(0, 255));
        n = 4'($urandom_range(1, 15));
        do_start(s, n);
        total++; if (chr.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", chr.out_valid); end
        capture(1'b0, 100);
        build_model(int'(s), int'(n));
        errs = (got.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) errs++;
        total++; if (errs !== 0 || !done_seen) begin bad++; $display("FAIL b2b_stream got=%0d errors done=%b exp=0 1", errs, done_seen); end
    endtask

    // Behavioural recognizer: accepts after each char iff the prefix is digit (op digit)*.
    task automatic test_random_loopback;
        logic [7:0] s;
        logic [3:0] n;
        int         errs;
        int         rec_errs;
        bit         ok;
        bit         is_d;
        bit         rec;
        for (int t = 0; t < 20; t++) begin
            s = 8'($urandom_range(0, 255));
            n = 4'($urandom_range(0, 15));
            do_start(s, n);
            capture(1'b1, 200);
            build_model(int'(s), int'(n));
            errs = (got.size() == exp_q.size()) ? 0 : 1;
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) errs++;
            total++; if (errs !== 0 || hold_err !== 0 || !done_seen) begin bad++; $display("FAIL rand%0d seed=%h n=%0d got errs=%0d hold=%0d done=%b exp=0 0 1", t, s, n, errs, hold_err, done_seen); end
            ok = 1'b1;
            rec_errs = 0;
            for (int i = 0; i < got.size(); i++) begin
                is_d = (got[i] >= 8'h30 && got[i] <= 8'h39);
                if (i % 2 == 0) ok = ok && is_d;
                else            ok = ok && (got[i] == 8'h2B || got[i] == 8'h2A);
                rec = ok && is_d;
                if (rec !== (i % 2 == 0)) rec_errs++;
            end
            if (got.size() % 2 == 0) rec_errs++;
            total++; if (rec_errs !== 0) begin bad++; $display("FAIL rand%0d_recognizer got=%0d errors exp=0", t, rec_errs); end
        end
    endtask

    initial begin
        chr.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_fold();
        test_backpressure();
        test_busy_start_and_reset();
        test_back_to_back();
        test_random_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
